dm_access_ctrl: RTL and testbench

//  Sequences MEM-stage load/store accesses to a variable-latency data memory over a req/gnt/rvalid handshake.

---
 rtl/dm_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// It drives a req/gnt/rvalid handshake, stalls the pipeline while an access is in flight,
// registers load data for writeback and aborts an access that hangs past a cycle budget.
module dm_access_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [3:0]        req_be_i,
  input  logic              flush_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  output logic [3:0]        dm_be_o,
  input  logic              dm_gnt_i,
  input  logic              dm_rvalid_i,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              err_o
);

  // The counter only has to reach TIMEOUT_CYC-1, where it saturates.
  localparam int unsigned    CntW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              drop_q;
  logic              dm_req_q;
  logic              dm_we_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_q;
  logic [3:0]        dm_be_q;
  logic [DATA_W-1:0] load_data_q;
  logic              load_valid_q;
  logic              err_q;

  logic            timeout_hit;
  logic [CntW-1:0] cnt_inc;

  // Budget check and saturating increment for the REQ+WAIT cycle counter.
  always_comb begin
    timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CntLast);
    cnt_inc     = (cnt_q == CntLast) ? cnt_q : cnt_q + 1'b1;
  end

  // Access sequencer with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dm_be_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && !flush_i) begin
            dm_we_q    <= req_we_i;
            dm_addr_q  <= req_addr_i;
            dm_wdata_q <= req_wdata_i;
            dm_be_q    <= req_be_i;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            dm_req_q   <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (dm_gnt_i) begin
            dm_req_q <= 1'b0;
            if (dm_we_q) begin
              state_q <= StDone;
            end else if (dm_rvalid_i) begin
              load_data_q  <= dm_rdata_i;
              load_valid_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              // Once granted the response must still be consumed, so a flush only marks it.
              drop_q  <= flush_i;
              cnt_q   <= cnt_inc;
              state_q <= StWait;
            end
          end else if (timeout_hit) begin
            dm_req_q    <= 1'b0;
            err_q       <= 1'b1;
            load_data_q <= '0;
            state_q     <= StDone;
          end else if (flush_i) begin
            dm_req_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWait: begin
          if (dm_rvalid_i) begin
            if (drop_q || flush_i) begin
              state_q <= StIdle;
            end else begin
              load_data_q  <= dm_rdata_i;
              load_valid_q <= 1'b1;
              state_q      <= StDone;
            end
          end else if (timeout_hit) begin
            err_q       <= 1'b1;
            load_data_q <= '0;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_inc;
            if (flush_i) drop_q <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall starts combinationally in IDLE so the MEM instruction is frozen before REQ.
  always_comb begin
    stall_o = ((state_q == StIdle) && req_valid_i && !flush_i) ||
              (state_q == StReq) || (state_q == StWait);
  end

  assign dm_req_o     = dm_req_q;
  assign dm_we_o      = dm_we_q;
  assign dm_addr_o    = dm_addr_q;
  assign dm_wdata_o   = dm_wdata_q;
  assign dm_be_o      = dm_be_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: scripted memory responder plus a scoreboard of result pulses.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i, flush_i;
  logic [15:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        dm_req_o, dm_we_o;
  logic [15:0] dm_addr_o;
  logic [31:0] dm_wdata_o;
  logic [3:0]  dm_be_o;
  logic        dm_gnt_i, dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic        stall_o, load_valid_o, err_o;
  logic [31:0] load_data_o;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Values seen on the memory port during the first request cycle.
  logic        seen_we;
  logic [15:0] seen_addr;
  logic [31:0] seen_wdata;
  logic [3:0]  seen_be;

  dm_access_ctrl #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .flush_i(flush_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .dm_be_o(dm_be_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Runs one access from an IDLE negedge. gnt_at: grant on the Nth request cycle (0 = never);
  // rvalid arrives rv_lat cycles after the grant cycle; flush_at: cycle index of a flush (-1 none).
  task automatic run_access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] rdata, input int gnt_at,
                            input int rv_lat, input int flush_at, output int stall_cyc,
                            output int req_cyc, output bit timed_out, output logic end_req,
                            output logic post_pulse);
    int k = 0;
    int gnt_cyc = -1;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_be_i = be; dm_rdata_i = rdata;
    stall_cyc = 0; req_cyc = 0; timed_out = 1'b1; end_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (load_valid_o) obs_q.push_back('{1'b0, load_data_o});
      if (err_o) obs_q.push_back('{1'b1, load_data_o});
      if (stall_o) stall_cyc++;
      if (dm_req_o) begin
        k++;
        req_cyc++;
        if (k == 1) begin
          seen_we = dm_we_o; seen_addr = dm_addr_o; seen_wdata = dm_wdata_o; seen_be = dm_be_o;
        end
      end
      flush_i = 1'b0; dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0;
      if (!stall_o) begin
        timed_out = 1'b0;
        end_req = dm_req_o;
        break;
      end
      if (c == flush_at) begin
        flush_i = 1'b1;
        req_valid_i = 1'b0;
      end
      if (dm_req_o && gnt_at != 0 && k == gnt_at) begin
        dm_gnt_i = 1'b1;
        gnt_cyc = c;
      end
      if (!we && gnt_cyc >= 0 && c == gnt_cyc + rv_lat) dm_rvalid_i = 1'b1;
      @(negedge clk);
    end
    req_valid_i = 1'b0; flush_i = 1'b0; dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0;
    @(negedge clk);
    #1;
    post_pulse = load_valid_o | err_o;
    if (load_valid_o || err_o) obs_q.push_back('{err_o, load_data_o});
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h1234;
    req_wdata_i = 32'hFFFF_FFFF; req_be_i = 4'hF; flush_i = 1'b0;
    dm_gnt_i = 1'b1; dm_rvalid_i = 1'b1; dm_rdata_i = 32'hA5A5_A5A5;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dm_req_o, dm_we_o, load_valid_o, err_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got req/we/lv/err=%b want 0000",
               {dm_req_o, dm_we_o, load_valid_o, err_o});
    end
    n_cmp++;
    if ({dm_addr_o, dm_wdata_o, dm_be_o, load_data_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%h ld=%h want all zero",
               dm_addr_o, dm_wdata_o, dm_be_o, load_data_o);
    end
    req_valid_i = 1'b0; dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_stall: got %b want 0", stall_o);
    end
  endtask

  task automatic test_store();
    int st, rq; bit to; logic er, pp;
    ev_t e, o;
    run_access(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1, 0, -1, st, rq, to, er, pp);
    n_cmp++;
    if ({to, st, rq} !== {1'b0, 32'd2, 32'd1}) begin
      n_bad++;
      $display("FAIL store_timing: got hang=%0d stall=%0d req=%0d want 0/2/1", to, st, rq);
    end
    n_cmp++;
    if ({seen_we, seen_addr, seen_wdata, seen_be} !== {1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF}) begin
      n_bad++;
      $display("FAIL store_port: got we=%b addr=%h wdata=%h be=%h want 1/0010/deadbeef/f",
               seen_we, seen_addr, seen_wdata, seen_be);
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      o = obs_q.pop_front();
      $display("FAIL store_pulse: got err=%b data=%h want no pulse", o.is_err, o.data);
    end
    obs_q.delete();
    e = '0;
  endtask

  task automatic test_load_wait();
    int st, rq; bit to; logic er, pp;
    ev_t e, o;
    exp_q.push_back('{1'b0, 32'h1234_5678});
    run_access(1'b0, 16'h0020, 32'h0, 4'hF, 32'h1234_5678, 3, 3, -1, st, rq, to, er, pp);
    n_cmp++;
    if ({to, st, rq} !== {1'b0, 32'd7, 32'd3}) begin
      n_bad++;
      $display("FAIL load_wait_timing: got hang=%0d stall=%0d req=%0d want 0/7/3", to, st, rq);
    end
    n_cmp++;
    if (pp !== 1'b0) begin
      n_bad++;
      $display("FAIL load_wait_onepulse: got pulse after DONE=%b want 0", pp);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL load_wait_sb: got no pulse want data=%h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL load_wait_sb: got err=%b data=%h want err=%b data=%h",
                   o.is_err, o.data, e.is_err, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL load_wait_extra: got %0d extra pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int st, rq; bit to; logic er, pp;
    ev_t e, o;
    exp_q.push_back('{1'b0, 32'hCAFE_F00D});
    run_access(1'b0, 16'h0030, 32'h0, 4'h3, 32'hCAFE_F00D, 1, 0, -1, st, rq, to, er, pp);
    n_cmp++;
    if ({to, st, rq} !== {1'b0, 32'd2, 32'd1}) begin
      n_bad++;
      $display("FAIL fast_load_timing: got hang=%0d stall=%0d req=%0d want 0/2/1", to, st, rq);
    end
    n_cmp++;
    if ({seen_we, seen_addr, seen_be} !== {1'b0, 16'h0030, 4'h3}) begin
      n_bad++;
      $display("FAIL fast_load_port: got we=%b addr=%h be=%h want 0/0030/3",
               seen_we, seen_addr, seen_be);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL fast_load_sb: got no pulse want data=%h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL fast_load_sb: got err=%b data=%h want err=%b data=%h",
                   o.is_err, o.data, e.is_err, e.data);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_flush();
    int st, rq; bit to; logic er, pp;
    // Flush while requesting, never granted.
    run_access(1'b0, 16'h0040, 32'h0, 4'hF, 32'h1111_1111, 0, 0, 2, st, rq, to, er, pp);
    n_cmp++;
    if ({to, st, rq, er} !== {1'b0, 32'd3, 32'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL flush_req: got hang=%0d stall=%0d req=%0d req_at_end=%b want 0/3/2/0",
               to, st, rq, er);
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL flush_req_pulse: got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
    // Flush after grant: the response is swallowed and the old load data is kept.
    run_access(1'b0, 16'h0044, 32'h0, 4'hF, 32'h5555_5555, 1, 3, 2, st, rq, to, er, pp);
    n_cmp++;
    if ({to, st, rq} !== {1'b0, 32'd5, 32'd1}) begin
      n_bad++;
      $display("FAIL flush_wait: got hang=%0d stall=%0d req=%0d want 0/5/1", to, st, rq);
    end
    n_cmp++;
    if (obs_q.size() !== 0 || load_data_o !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL flush_wait_data: got pulses=%0d ld=%h want 0/cafef00d",
               obs_q.size(), load_data_o);
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    int st, rq; bit to; logic er, pp;
    ev_t e, o;
    exp_q.push_back('{1'b1, 32'h0});
    run_access(1'b0, 16'h0050, 32'h0, 4'hF, 32'h9999_9999, 0, 0, -1, st, rq, to, er, pp);
    n_cmp++;
    if ({to, st, rq, er} !== {1'b0, 32'd9, 32'd8, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_timing: got hang=%0d stall=%0d req=%0d req_at_end=%b want 0/9/8/0",
               to, st, rq, er);
    end
    // A normal load right after the abort.
    exp_q.push_back('{1'b0, 32'h0BAD_CAFE});
    run_access(1'b0, 16'h0054, 32'h0, 4'hF, 32'h0BAD_CAFE, 2, 1, -1, st, rq, to, er, pp);
    n_cmp++;
    if ({to, st, rq} !== {1'b0, 32'd4, 32'd2}) begin
      n_bad++;
      $display("FAIL post_timeout_timing: got hang=%0d stall=%0d req=%0d want 0/4/2", to, st, rq);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL timeout_sb: got no pulse want err=%b data=%h", e.is_err, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL timeout_sb: got err=%b data=%h want err=%b data=%h",
                   o.is_err, o.data, e.is_err, e.data);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h0060; req_be_i = 4'hF;
    dm_rdata_i = 32'h7777_7777;
    @(negedge clk);                 // REQ
    dm_gnt_i = 1'b1;
    @(negedge clk);                 // WAIT
    dm_gnt_i = 1'b0;
    n_cmp++;
    if ({dm_req_o, stall_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_mid_wait: got req=%b stall=%b want 0/1", dm_req_o, stall_o);
    end
    rst = 1'b1; req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({dm_req_o, dm_we_o, stall_o, load_valid_o, err_o, dm_addr_o, dm_be_o, load_data_o}
        !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got req=%b stall=%b addr=%h be=%h ld=%h want all zero",
               dm_req_o, stall_o, dm_addr_o, dm_be_o, load_data_o);
    end
    dm_rvalid_i = 1'b1;
    @(negedge clk);
    dm_rvalid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({dm_req_o, stall_o, load_valid_o, load_data_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_late_rvalid: got req=%b stall=%b lv=%b ld=%h want all zero",
               dm_req_o, stall_o, load_valid_o, load_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_wait();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
